// File: rtl/gate_unit_pipe.sv
// gate_unit_pipe: registered bitwise gate unit with a 2-entry output/skid store; GATE_UNIT_COUNT_EN adds op_count
module gate_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef GATE_UNIT_COUNT_EN
    ,
    output logic [15:0]      op_count
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] res, skid;
    logic accept, consume;
    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;
    // bitwise result for the sampled op; op 110 uses c as a per-bit select
    always_comb begin
        case (op)
            3'b000:  res = a & b;
            3'b001:  res = a | b;
            3'b010:  res = a ^ b;
            3'b011:  res = ~(a & b);
            3'b100:  res = ~(a | b);
            3'b101:  res = ~(a ^ b);
            3'b110:  res = (a & b & ~c) | ((a | b) & c);
            default: res = a;
        endcase
    end
    // occupancy next state; accept cannot occur in TWO since in_ready is low there
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   state_nxt = accept ? ONE : EMPTY;
            ONE:     state_nxt = accept ? (consume ? ONE : TWO) : (consume ? EMPTY : ONE);
            default: state_nxt = consume ? ONE : TWO;
        endcase
    end
    // result is present whenever the store holds at least one entry
    always_comb out_valid = (state != EMPTY);
    // state, registered in_ready and the two data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
            out      <= '0;
            skid     <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
            if (accept && (state == EMPTY || (state == ONE && consume)))
                out <= res;
            else if (state == TWO && consume)
                out <= skid;
            if (accept && state == ONE && !consume)
                skid <= res;
        end
    end
`ifdef GATE_UNIT_COUNT_EN
    // count consumed results, wrapping naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            op_count <= '0;
        else if (consume)
            op_count <= op_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_gate_unit_pipe.sv
// tb_gate_unit_pipe: directed, table-driven checks of gate_unit_pipe at WIDTH=8
module tb_gate_unit_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'hF0, b = 8'hCC, c = 8'hAA;
    logic [2:0] op = 3'b000;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out;
`ifdef GATE_UNIT_COUNT_EN
    logic [15:0] op_count;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] exp;
    } vec_t;
    vec_t v[8];

    gate_unit_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
`ifdef GATE_UNIT_COUNT_EN
        , .op_count(op_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0] = '{3'b000, 8'hC0};
        v[1] = '{3'b001, 8'hFC};
        v[2] = '{3'b010, 8'h3C};
        v[3] = '{3'b011, 8'h3F};
        v[4] = '{3'b100, 8'h03};
        v[5] = '{3'b101, 8'hC3};
        v[6] = '{3'b110, 8'hE8};
        v[7] = '{3'b111, 8'hF0};

        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        step();
        chk("rst_held_in_ready", 32'(in_ready), 0);
        #3 rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_empty", 32'(out_valid), 0);

        // streaming all ops with the sink always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = v[i].op;
            step();
            chk($sformatf("op%0d_out", i), 32'(out), 32'(v[i].exp));
            chk($sformatf("op%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("op%0d_ready", i), 32'(in_ready), 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", 32'(out_valid), 0);

        // back-pressure: three bundles, only two fit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 3'b000;
        step();
        chk("bp1_out", 32'(out), 32'hC0);
        chk("bp1_ready", 32'(in_ready), 1);
        op = 3'b001;
        step();
        chk("bp2_ready", 32'(in_ready), 0);
        chk("bp2_out", 32'(out), 32'hC0);
        op = 3'b010;
        step();
        chk("bp3_ready", 32'(in_ready), 0);
        chk("bp3_out_held", 32'(out), 32'hC0);
        chk("bp3_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        op = 3'b111;

        // one consume pulse from TWO
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("two_pop_out", 32'(out), 32'hFC);
        chk("two_pop_ready", 32'(in_ready), 1);
        chk("two_pop_valid", 32'(out_valid), 1);
        step();
        chk("one_hold_out", 32'(out), 32'hFC);
        chk("one_hold_valid", 32'(out_valid), 1);

        // simultaneous accept and consume in ONE
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = 3'b010;
        step();
        chk("pass1_out", 32'(out), 32'h3C);
        chk("pass1_valid", 32'(out_valid), 1);
        chk("pass1_ready", 32'(in_ready), 1);
        op = 3'b011;
        step();
        chk("pass2_out", 32'(out), 32'h3F);
        in_valid = 1'b0;
        step();
        chk("pass_drain", 32'(out_valid), 0);

        // asynchronous reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 3'b100;
        step();
        op = 3'b101;
        step();
        in_valid = 1'b0;
        chk("full_ready", 32'(in_ready), 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_out", 32'(out), 0);
        chk("arst_ready", 32'(in_ready), 0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("arst_rel_ready", 32'(in_ready), 1);
        chk("arst_rel_valid", 32'(out_valid), 0);
        step();
        chk("arst_no_stale", 32'(out_valid), 0);
        chk("arst_out_zero", 32'(out), 0);

`ifdef GATE_UNIT_COUNT_EN
        rst = 1'b1;
        #3 rst = 1'b0;
        step();
        chk("cnt_reset", 32'(op_count), 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 65537; i++) step();
        in_valid = 1'b0;
        step();
        chk("cnt_wrap", 32'(op_count), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gate_unit_pipe.md
GATE_UNIT_PIPE -- requirements
Module: gate_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result bit width (legal 1..64).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1, operand bundle present.
REQ-005 SHALL have port in_ready, output, 1, bundle accepted when in_valid and in_ready are both high at a clk edge.
REQ-006 SHALL have ports a, b, c, input, WIDTH each: operands, with c acting as the per-bit select for op 110.
REQ-007 SHALL have port op, input, 3, operation code sampled with the operands.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, result consumed when out_valid and out_ready are both high.
REQ-010 SHALL have port out, output, WIDTH, registered result.

Function
REQ-011 SHALL compute the op encodings bitwise: 000 a&b, 001 a|b, 010 a^b, 011 ~(a&b), 100 ~(a|b), 101 ~(a^b), 110 (a&b&~c)|((a|b)&c), 111 a.
REQ-012 SHALL register the result: the accepted bundle appears on out with out_valid one cycle after acceptance if the output stage is free.
REQ-013 SHALL hold a 2-entry store (output register plus skid register); the occupancy FSM has states EMPTY, ONE and TWO.
REQ-014 SHALL make these FSM transitions: EMPTY->ONE on accept; ONE->EMPTY on consume without accept; ONE->TWO on accept without consume; ONE stays ONE on accept and consume in the same cycle; TWO->ONE on consume.
REQ-015 SHALL drive in_ready from a register only, high exactly when the state is not TWO, with no combinational path from out_ready.
REQ-016 SHALL drive out_valid high exactly in states ONE and TWO.
REQ-017 SHALL, in TWO, move the skid entry into the output register on consume, preserving arrival order.
REQ-018 SHALL hold out and out_valid stable while out_valid is high and out_ready is low.
REQ-019 SHALL ignore input bundles while in_ready is low; no data is lost or duplicated.
REQ-020 SHALL sustain one result per cycle when out_ready is held high.
REQ-021 SHALL treat an op value arriving with in_valid low as don't-care; it has no effect on state.

Reset
REQ-022 SHALL, on rst high and without waiting for a clock, force the state to EMPTY, out_valid to 0, out to 0, in_ready to 0, and the skid register to 0.
REQ-023 SHALL, while rst is high, keep in_ready at 0.
REQ-024 SHALL raise in_ready at the first clk edge after rst deasserts.
REQ-025 SHALL, on reset mid-operation, discard all in-flight results.

Configuration
REQ-026 SHALL, when GATE_UNIT_COUNT_EN is defined, add an output port op_count (16 bits) counting consumed results, wrapping 0xFFFF->0x0000, reset to 0, and incrementing by at most 1 per cycle.
REQ-027 SHALL, when GATE_UNIT_COUNT_EN is undefined, omit op_count and its logic entirely; all other behaviour is identical.

Verification (WIDTH=8)
REQ-028 SHALL verify: a=0xF0, b=0xCC, c=0xAA, and op stepped 000..111 with out_ready=1 -> out 0xC0,0xFC,0x3C,0x3F,0x03,0xC3,0xE8,0xF0 on consecutive cycles, each one cycle after its input.
REQ-029 SHALL verify: out_ready=0 and three back-to-back bundles -> first two accepted, in_ready low from the cycle after the second, out held at the first result.
REQ-030 SHALL verify: from TWO, out_ready pulsed high for one cycle -> second result on out next cycle, in_ready high, state ONE.
REQ-031 SHALL verify: accept and consume in the same cycle in state ONE -> state stays ONE, new result on out, no bubble.
REQ-032 SHALL verify: rst asserted between clk edges while in TWO -> out_valid=0 and out=0 immediately, with no stale result after release.
REQ-033 SHALL verify: with GATE_UNIT_COUNT_EN defined, 65537 consumed results -> op_count=1.
